// File: rtl/seg7_scan_display.sv
// seg7_scan_display: holds a 32-bit word and scans it as 8 hex digits onto a
// common-anode 8-digit seven-segment display. A new word only takes effect at
// a frame boundary, so a single scan never mixes two words.
//
// Ports:
//   clk        system clock, rising edge
//   clr        asynchronous active-low reset
//   upd        one-cycle strobe that captures upd_data
//   upd_data   word to display; digit k shows upd_data[4k+3:4k]
//   blank_lz   1 = suppress leading zeros (digit 0 is never blanked)
//   an         digit enables, active-low; an[0] is the rightmost digit
//   seg        segments, active-low; seg[0..6] = a..g, seg[7] = dp
//   frame_done one-cycle pulse in the cycle after each frame boundary
module seg7_scan_display #(
    parameter int unsigned CLK_DIV = 100000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        upd,
    input  logic [31:0] upd_data,
    input  logic        blank_lz,
    output logic [7:0]  an,
    output logic [7:0]  seg,
    output logic        frame_done
);

    localparam int unsigned PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

    logic [PW-1:0] presc, presc_nxt;
    logic [2:0]    idx, idx_nxt;
    logic [31:0]   shown, shown_nxt;
    logic [31:0]   pend_data, pend_data_nxt;
    logic          pend, pend_nxt;

    logic          tick;
    logic          boundary;
    logic [3:0]    nib;
    logic [2:0]    hi;
    logic          blank;
    logic [7:0]    an_nxt;
    logic [7:0]    seg_nxt;

    // Hex digit to active-low segment code, decimal point off.
    function automatic logic [7:0] seg_code(input logic [3:0] n);
        logic [7:0] c;
        case (n)
            4'h0: c = 8'hC0;
            4'h1: c = 8'hF9;
            4'h2: c = 8'hA4;
            4'h3: c = 8'hB0;
            4'h4: c = 8'h99;
            4'h5: c = 8'h92;
            4'h6: c = 8'h82;
            4'h7: c = 8'hF8;
            4'h8: c = 8'h80;
            4'h9: c = 8'h90;
            4'hA: c = 8'h88;
            4'hB: c = 8'h83;
            4'hC: c = 8'hC6;
            4'hD: c = 8'hA1;
            4'hE: c = 8'h86;
            default: c = 8'h8E;
        endcase
        return c;
    endfunction

    // Prescaler, digit index and word handshake next-state.
    always_comb begin
        tick          = (presc == PRESC_MAX);
        boundary      = tick && (idx == 3'd7);
        presc_nxt     = tick ? '0 : presc + PW'(1);
        idx_nxt       = tick ? idx + 3'd1 : idx;
        shown_nxt     = shown;
        pend_data_nxt = pend_data;
        pend_nxt      = pend;

        if (boundary) begin
            // A strobe on the boundary itself beats the older pending word.
            if (upd) begin
                shown_nxt = upd_data;
            end else if (pend) begin
                shown_nxt = pend_data;
            end
            pend_nxt = 1'b0;
        end else if (upd) begin
            pend_data_nxt = upd_data;
            pend_nxt      = 1'b1;
        end
    end

    // Output stage: current digit select, segment decode, leading-zero blanking.
    always_comb begin
        nib = shown[{idx, 2'b00} +: 4];
        hi  = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (shown[i*4 +: 4] != 4'd0) begin
                hi = 3'(i);
            end
        end
        blank   = blank_lz && (idx > hi);
        an_nxt  = ~(8'd1 << idx);
        seg_nxt = blank ? 8'hFF : seg_code(nib);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            presc      <= '0;
            idx        <= 3'd0;
            shown      <= 32'd0;
            pend_data  <= 32'd0;
            pend       <= 1'b0;
            an         <= 8'hFF;
            seg        <= 8'hFF;
            frame_done <= 1'b0;
        end else begin
            presc      <= presc_nxt;
            idx        <= idx_nxt;
            shown      <= shown_nxt;
            pend_data  <= pend_data_nxt;
            pend       <= pend_nxt;
            an         <= an_nxt;
            seg        <= seg_nxt;
            frame_done <= boundary;
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Testbench for seg7_scan_display with CLK_DIV=4 (32-cycle frames).
// Outputs are sampled on the falling clock edge.
module tb_seg7_scan_display;

    logic        clk;
    logic        clr;
    logic        upd;
    logic [31:0] upd_data;
    logic        blank_lz;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;

    seg7_scan_display #(.CLK_DIV(4)) dut (
        .clk        (clk),
        .clr        (clr),
        .upd        (upd),
        .upd_data   (upd_data),
        .blank_lz   (blank_lz),
        .an         (an),
        .seg        (seg),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        logic        blank;
        logic [63:0] exp_seg;   // digit k expected code in bits [8k+7:8k]
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance to the next falling edge where frame_done is high (bounded).
    task automatic wait_frame();
        bit found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        chk("frame_done_timeout", 32'(found), 32'd1);
    endtask

    // Called on the frame_done falling edge; checks every digit of the frame.
    task automatic check_frame(input string name, input logic [63:0] exp);
        logic [7:0] e_an;
        @(negedge clk);
        chk({name, "_fd_low"}, 32'(frame_done), 32'd0);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) repeat (4) @(negedge clk);
            e_an = ~(8'd1 << k);
            chk({name, "_an"}, 32'(an), 32'(e_an));
            chk({name, "_seg"}, 32'(seg), 32'(exp[k*8 +: 8]));
        end
    endtask

    // First frame after reset release: each digit held 4 cycles, all zeros.
    task automatic check_from_reset(input string name);
        logic [7:0] e_an;
        for (int n = 1; n <= 32; n++) begin
            @(negedge clk);
            e_an = ~(8'd1 << ((n - 1) / 4));
            chk({name, "_an"}, 32'(an), 32'(e_an));
            chk({name, "_seg"}, 32'(seg), 32'h0000_00C0);
            chk({name, "_fd"}, 32'(frame_done), 32'(n == 32));
        end
    endtask

    task automatic pulse_upd(input logic [31:0] w);
        upd_data = w;
        upd      = 1'b1;
        @(negedge clk);
        upd      = 1'b0;
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{32'h0000_0000, 1'b0, 64'hC0C0C0C0C0C0C0C0};
        vecs[1] = '{32'h0000_0009, 1'b1, 64'hFFFFFFFFFFFFFF90};
        vecs[2] = '{32'h0000_0000, 1'b1, 64'hFFFFFFFFFFFFFFC0};
        vecs[3] = '{32'h0001_0000, 1'b1, 64'hFFFFFFF9C0C0C0C0};
        vecs[4] = '{32'h0001_0000, 1'b0, 64'hC0C0C0F9C0C0C0C0};
        vecs[5] = '{32'h89AB_CDEF, 1'b1, 64'h80908883C6A1868E};
        vecs[6] = '{32'h7654_3210, 1'b0, 64'hF8829299B0A4F9C0};
        vecs[7] = '{32'h0000_F000, 1'b1, 64'hFFFFFFFF8EC0C0C0};
        vecs[8] = '{32'h0050_0300, 1'b1, 64'hFFFF92C0C0B0C0C0};

        clr      = 1'b0;
        upd      = 1'b0;
        upd_data = 32'd0;
        blank_lz = 1'b0;

        // Reset state and first frame after release.
        repeat (2) @(negedge clk);
        chk("rst_an", 32'(an), 32'h0000_00FF);
        chk("rst_seg", 32'(seg), 32'h0000_00FF);
        chk("rst_fd", 32'(frame_done), 32'd0);
        clr = 1'b1;
        check_from_reset("t1");

        // Mid-frame update: rest of this frame still shows zeros.
        @(negedge clk);
        chk("t2_d0_an", 32'(an), 32'h0000_00FE);
        chk("t2_d0_seg", 32'(seg), 32'h0000_00C0);
        pulse_upd(32'h1234_ABCD);
        repeat (3) @(negedge clk);
        for (int k = 1; k < 8; k++) begin
            if (k > 1) repeat (4) @(negedge clk);
            chk("t2_old_seg", 32'(seg), 32'h0000_00C0);
        end
        wait_frame();
        check_frame("t2_new", 64'hF9A4B0998883C6A1);

        // Two updates before the boundary: only the last one is shown.
        wait_frame();
        repeat (2) @(negedge clk);
        pulse_upd(32'h1111_1111);
        repeat (5) @(negedge clk);
        pulse_upd(32'h0000_0009);
        blank_lz = 1'b1;
        wait_frame();
        check_frame("t3", 64'hFFFFFFFFFFFFFF90);

        // Update in the boundary cycle beats the pending word.
        blank_lz = 1'b0;
        wait_frame();
        repeat (3) @(negedge clk);
        pulse_upd(32'h0000_0005);
        repeat (27) @(negedge clk);
        upd_data = 32'hFFFF_FFFF;
        upd      = 1'b1;
        @(negedge clk);
        chk("t4_boundary_fd", 32'(frame_done), 32'd1);
        upd = 1'b0;
        check_frame("t4_new", 64'h8E8E8E8E8E8E8E8E);
        wait_frame();
        check_frame("t4_hold", 64'h8E8E8E8E8E8E8E8E);

        // Table of words and blanking modes.
        foreach (vecs[i]) begin
            wait_frame();
            repeat (3) @(negedge clk);
            pulse_upd(vecs[i].word);
            blank_lz = vecs[i].blank;
            wait_frame();
            check_frame($sformatf("vec%0d", i), vecs[i].exp_seg);
        end

        // Reset mid-frame with a pending word: it must never be displayed.
        blank_lz = 1'b0;
        wait_frame();
        repeat (3) @(negedge clk);
        pulse_upd(32'h5555_5555);
        repeat (5) @(negedge clk);
        clr = 1'b0;
        #1;
        chk("t6_rst_an", 32'(an), 32'h0000_00FF);
        chk("t6_rst_seg", 32'(seg), 32'h0000_00FF);
        chk("t6_rst_fd", 32'(frame_done), 32'd0);
        repeat (2) @(negedge clk);
        clr = 1'b1;
        check_from_reset("t6");
        check_frame("t6_after", 64'hC0C0C0C0C0C0C0C0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
